video_frame_framer: RTL and testbench

- Upstream neighbour of the motion detector. Takes a raw camera pixel stream marked with start-of-frame (tuser) and produces a clean frame stream for the detector's s_axis input.
- Every output frame is exactly width×height pixels, and tlast is asserted only on the final pixel.
- Short frames are padded, long frames are truncated, and pre-SOF garbage is discarded, so the detector's first-frame/background logic and address manager never lose frame alignment.

---
 rtl/video_framer_pkg.sv | 13 +
 rtl/axis_skid_fifo2.sv | 54 +++++
 rtl/video_frame_framer.sv | 185 ++++++++++++++++++
 tb/tb_video_frame_framer.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/video_framer_pkg.sv
// Shared types and constants for the video frame framer and its neighbours.
package video_framer_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_SOF = 2'd1,
        PASS     = 2'd2,
        PAD      = 2'd3
    } framer_state_t;

    localparam logic [31:0] PAD_PIXEL_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/axis_skid_fifo2.sv
// Two-entry skid FIFO for a valid/ready stream. Output side is fully registered;
// room depends only on local state so the producer never sees a path from out_ready.
module axis_skid_fifo2 #(
    parameter int DATA_BITS = 33
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  logic [DATA_BITS-1:0] push_data,
    output logic                 room,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATA_BITS-1:0] out_data
);

    logic                 out_valid_r;
    logic [DATA_BITS-1:0] out_data_r;
    logic                 skid_valid_r;
    logic [DATA_BITS-1:0] skid_data_r;
    logic                 pop_s;

    assign pop_s     = out_valid_r && out_ready;
    assign room      = !skid_valid_r;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;

    // Output/skid registers: the skid entry only fills while the output head is stalled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_r  <= 1'b0;
            out_data_r   <= {DATA_BITS{1'b0}};
            skid_valid_r <= 1'b0;
            skid_data_r  <= {DATA_BITS{1'b0}};
        end else if (!out_valid_r || pop_s) begin
            if (skid_valid_r) begin
                out_valid_r  <= 1'b1;
                out_data_r   <= skid_data_r;
                skid_valid_r <= push;
                if (push) begin
                    skid_data_r <= push_data;
                end
            end else begin
                out_valid_r <= push;
                if (push) begin
                    out_data_r <= push_data;
                end
            end
        end else if (push) begin
            skid_valid_r <= 1'b1;
            skid_data_r  <= push_data;
        end
    end

endmodule

// File: rtl/video_frame_framer.sv
// Re-frames a raw SOF-marked camera stream into exact width x height frames:
// pre-SOF junk dropped, short frames padded, long frames truncated.
module video_frame_framer
    import video_framer_pkg::*;
#(
    parameter int                      WIDTH_BITS   = 11,
    parameter int                      HEIGHT_BITS  = 10,
    parameter int                      STREAM_WIDTH = 32,
    parameter logic [STREAM_WIDTH-1:0] PAD_PIXEL    = STREAM_WIDTH'(PAD_PIXEL_DEFAULT),
    parameter int                      ERR_CNT_BITS = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cfg_valid,
    input  logic [WIDTH_BITS-1:0]   cfg_width,
    input  logic [HEIGHT_BITS-1:0]  cfg_height,
    output logic                    cfg_ready,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    input  logic [STREAM_WIDTH-1:0] s_axis_tdata,
    input  logic                    s_axis_tuser,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic [STREAM_WIDTH-1:0] m_axis_tdata,
    output logic                    m_axis_tlast,
    output logic                    frame_done,
    output logic [ERR_CNT_BITS-1:0] err_short_cnt,
    output logic [ERR_CNT_BITS-1:0] err_long_cnt
);

    localparam logic [WIDTH_BITS-1:0]  W_ONE = {{(WIDTH_BITS-1){1'b0}}, 1'b1};
    localparam logic [HEIGHT_BITS-1:0] H_ONE = {{(HEIGHT_BITS-1){1'b0}}, 1'b1};

    function automatic logic [ERR_CNT_BITS-1:0] sat_inc(input logic [ERR_CNT_BITS-1:0] v);
        if (&v) begin
            sat_inc = v;
        end else begin
            sat_inc = v + {{(ERR_CNT_BITS-1){1'b0}}, 1'b1};
        end
    endfunction

    framer_state_t           state_r, state_s;
    logic [WIDTH_BITS-1:0]   width_r, x_r, cur_x_s, x_s;
    logic [HEIGHT_BITS-1:0]  height_r, y_r, cur_y_s, y_s;
    logic                    long_armed_r, long_armed_s;
    logic [ERR_CNT_BITS-1:0] err_short_r, err_long_r;
    logic                    inc_short_s, inc_long_s, cfg_load_s;
    logic                    push_s, room_s, is_last_s, frame_done_r;
    logic [STREAM_WIDTH-1:0] push_data_s;

    // Frame position of the beat that would be emitted now; a SOF always lands at (0,0).
    always_comb begin
        cur_x_s   = (state_r == WAIT_SOF) ? {WIDTH_BITS{1'b0}} : x_r;
        cur_y_s   = (state_r == WAIT_SOF) ? {HEIGHT_BITS{1'b0}} : y_r;
        is_last_s = (cur_x_s == width_r - W_ONE) && (cur_y_s == height_r - H_ONE);
        if (cur_x_s == width_r - W_ONE) begin
            x_s = {WIDTH_BITS{1'b0}};
            y_s = (cur_y_s == height_r - H_ONE) ? {HEIGHT_BITS{1'b0}} : cur_y_s + H_ONE;
        end else begin
            x_s = cur_x_s + W_ONE;
            y_s = cur_y_s;
        end
    end

    // Next-state and handshake decode.
    always_comb begin
        state_s       = state_r;
        cfg_ready     = 1'b0;
        s_axis_tready = 1'b0;
        push_s        = 1'b0;
        push_data_s   = s_axis_tdata;
        inc_short_s   = 1'b0;
        inc_long_s    = 1'b0;
        cfg_load_s    = 1'b0;
        long_armed_s  = long_armed_r;
        case (state_r)
            IDLE: begin
                cfg_ready = 1'b1;
                if (cfg_valid) begin
                    cfg_load_s = 1'b1;
                    state_s    = ((cfg_width != {WIDTH_BITS{1'b0}}) &&
                                  (cfg_height != {HEIGHT_BITS{1'b0}})) ? WAIT_SOF : IDLE;
                end else begin
                    state_s = IDLE;
                end
            end
            WAIT_SOF: begin
                s_axis_tready = room_s;
                if (s_axis_tvalid && room_s) begin
                    if (s_axis_tuser) begin
                        push_s       = 1'b1;
                        long_armed_s = is_last_s;
                        state_s      = is_last_s ? WAIT_SOF : PASS;
                    end else begin
                        // Only the first overrun beat of a frame is counted.
                        inc_long_s   = long_armed_r;
                        long_armed_s = 1'b0;
                    end
                end else begin
                    state_s = WAIT_SOF;
                end
            end
            PASS: begin
                if (s_axis_tvalid && s_axis_tuser) begin
                    inc_short_s = 1'b1;
                    state_s     = PAD;
                end else begin
                    s_axis_tready = room_s;
                    if (s_axis_tvalid && room_s) begin
                        push_s       = 1'b1;
                        long_armed_s = is_last_s;
                        state_s      = is_last_s ? WAIT_SOF : PASS;
                    end else begin
                        state_s = PASS;
                    end
                end
            end
            PAD: begin
                push_data_s = PAD_PIXEL;
                if (room_s) begin
                    push_s       = 1'b1;
                    long_armed_s = 1'b0;
                    state_s      = is_last_s ? WAIT_SOF : PAD;
                end else begin
                    state_s = PAD;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Control, configuration, position and error-count registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= IDLE;
            width_r      <= {WIDTH_BITS{1'b0}};
            height_r     <= {HEIGHT_BITS{1'b0}};
            x_r          <= {WIDTH_BITS{1'b0}};
            y_r          <= {HEIGHT_BITS{1'b0}};
            long_armed_r <= 1'b0;
            err_short_r  <= {ERR_CNT_BITS{1'b0}};
            err_long_r   <= {ERR_CNT_BITS{1'b0}};
            frame_done_r <= 1'b0;
        end else begin
            state_r      <= state_s;
            long_armed_r <= long_armed_s;
            frame_done_r <= m_axis_tvalid && m_axis_tready && m_axis_tlast;
            if (cfg_load_s) begin
                width_r  <= cfg_width;
                height_r <= cfg_height;
                x_r      <= {WIDTH_BITS{1'b0}};
                y_r      <= {HEIGHT_BITS{1'b0}};
            end else if (push_s) begin
                x_r <= x_s;
                y_r <= y_s;
            end
            if (inc_short_s) begin
                err_short_r <= sat_inc(err_short_r);
            end
            if (inc_long_s) begin
                err_long_r <= sat_inc(err_long_r);
            end
        end
    end

    assign frame_done    = frame_done_r;
    assign err_short_cnt = err_short_r;
    assign err_long_cnt  = err_long_r;

    axis_skid_fifo2 #(
        .DATA_BITS(STREAM_WIDTH + 1)
    ) u_out_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push_s),
        .push_data({is_last_s, push_data_s}),
        .room     (room_s),
        .out_valid(m_axis_tvalid),
        .out_ready(m_axis_tready),
        .out_data ({m_axis_tlast, m_axis_tdata})
    );

endmodule

// File: tb/tb_video_frame_framer.sv
// Self-checking bench for video_frame_framer: directed table, hand sequences and
// randomized frames checked against a segment-level reference model.
module tb_video_frame_framer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cfg_valid = 1'b0;
    logic [10:0] cfg_width = 11'd0;
    logic [9:0]  cfg_height = 10'd0;
    logic        cfg_ready;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tready;
    logic [31:0] s_axis_tdata = 32'd0;
    logic        s_axis_tuser = 1'b0;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b1;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tlast;
    logic        frame_done;
    logic [15:0] err_short_cnt;
    logic [15:0] err_long_cnt;

    video_frame_framer dut (
        .clk(clk), .rst(rst),
        .cfg_valid(cfg_valid), .cfg_width(cfg_width), .cfg_height(cfg_height), .cfg_ready(cfg_ready),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .s_axis_tdata(s_axis_tdata), .s_axis_tuser(s_axis_tuser),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast),
        .frame_done(frame_done), .err_short_cnt(err_short_cnt), .err_long_cnt(err_long_cnt)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] d; logic u; } ibeat_t;
    typedef struct { logic [31:0] d; logic l; } obeat_t;
    typedef struct {
        int w; int h; int junk; int seg[4]; int stall;
        int exp_beats; int exp_frames; int exp_short; int exp_long;
    } vec_t;

    ibeat_t in_q[$];
    obeat_t got_q[$];
    obeat_t exp_q[$];
    int     got_cyc[$];
    int     checks = 0;
    int     errors = 0;
    int     cyc = 0;
    int     stall_pct = 0;
    int     fd_count = 0;
    int     first_acc_cyc = -1;
    int     m_short, m_long, m_frames;
    logic [31:0] data_ctr;
    vec_t   vecs[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(posedge clk);
        #1;
        m_axis_tready = (stall_pct == 0) ? 1'b1 : ($urandom_range(99) >= stall_pct);
    end

    // Output monitor: collects transfers, checks hold-under-stall and frame_done timing.
    initial begin
        logic        prev_stall;
        logic        prev_last_xfer;
        logic [31:0] prev_d;
        logic        prev_l;
        prev_stall = 1'b0; prev_last_xfer = 1'b0; prev_d = 32'd0; prev_l = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                prev_stall     = 1'b0;
                prev_last_xfer = 1'b0;
            end else begin
                if (prev_stall) begin
                    chk("hold_valid", {63'd0, m_axis_tvalid}, 64'd1);
                    chk("hold_data", {32'd0, m_axis_tdata}, {32'd0, prev_d});
                    chk("hold_last", {63'd0, m_axis_tlast}, {63'd0, prev_l});
                end
                chk("frame_done_timing", {63'd0, frame_done}, {63'd0, prev_last_xfer});
                if (frame_done) fd_count++;
                prev_stall     = m_axis_tvalid && !m_axis_tready;
                prev_d         = m_axis_tdata;
                prev_l         = m_axis_tlast;
                prev_last_xfer = m_axis_tvalid && m_axis_tready && m_axis_tlast;
                if (m_axis_tvalid && m_axis_tready) begin
                    got_q.push_back('{m_axis_tdata, m_axis_tlast});
                    got_cyc.push_back(cyc);
                end
            end
        end
    end

    // Reference: split accepted input into SOF segments, each cut or padded to n pixels.
    task automatic model(input int n);
        int  cnt;
        bit  inframe;
        bit  over;
        exp_q.delete();
        m_short = 0; m_long = 0; m_frames = 0;
        cnt = 0; inframe = 1'b0; over = 1'b0;
        foreach (in_q[i]) begin
            if (in_q[i].u) begin
                if (inframe && cnt < n) begin
                    m_short++;
                    for (int k = cnt; k < n; k++) exp_q.push_back('{32'd0, (k == n - 1)});
                    m_frames++;
                end
                inframe = 1'b1; cnt = 0; over = 1'b0;
            end
            if (inframe) begin
                if (cnt < n) begin
                    exp_q.push_back('{in_q[i].d, (cnt == n - 1)});
                    if (cnt == n - 1) m_frames++;
                    cnt++;
                end else if (!over) begin
                    m_long++;
                    over = 1'b1;
                end
            end
        end
    endtask

    task automatic do_reset();
        s_axis_tvalid = 1'b0; cfg_valid = 1'b0;
        rst = 1'b0;
        #1;
        chk("rst_m_tvalid", {63'd0, m_axis_tvalid}, 64'd0);
        chk("rst_m_tdata", {32'd0, m_axis_tdata}, 64'd0);
        chk("rst_m_tlast", {63'd0, m_axis_tlast}, 64'd0);
        chk("rst_frame_done", {63'd0, frame_done}, 64'd0);
        chk("rst_err_short", {48'd0, err_short_cnt}, 64'd0);
        chk("rst_err_long", {48'd0, err_long_cnt}, 64'd0);
        chk("rst_s_tready", {63'd0, s_axis_tready}, 64'd0);
        got_q.delete(); got_cyc.delete(); fd_count = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        chk("rst_cfg_ready", {63'd0, cfg_ready}, 64'd1);
    endtask

    task automatic configure(input int w, input int h);
        cfg_valid = 1'b1; cfg_width = 11'(w); cfg_height = 10'(h);
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
        chk("cfg_ready_after", {63'd0, cfg_ready}, (w != 0 && h != 0) ? 64'd0 : 64'd1);
    endtask

    task automatic add_seg(input int len, input bit rnd);
        for (int k = 0; k < len; k++) begin
            in_q.push_back('{rnd ? $urandom : data_ctr, (k == 0)});
            data_ctr++;
        end
    endtask

    task automatic send_beats(input int gap_pct);
        bit accepted;
        bit first;
        first = 1'b1;
        first_acc_cyc = -1;
        foreach (in_q[i]) begin
            if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
                s_axis_tvalid = 1'b0;
                @(posedge clk);
                #1;
            end
            s_axis_tvalid = 1'b1; s_axis_tdata = in_q[i].d; s_axis_tuser = in_q[i].u;
            accepted = 1'b0;
            for (int t = 0; t < 300 && !accepted; t++) begin
                @(negedge clk);
                accepted = s_axis_tready;
                if (accepted && first) begin
                    first_acc_cyc = cyc;
                    first = 1'b0;
                end
                @(posedge clk);
                #1;
            end
            if (!accepted) begin
                chk("input_accept_timeout", 64'd0, 64'd1);
                s_axis_tvalid = 1'b0;
                return;
            end
        end
        s_axis_tvalid = 1'b0; s_axis_tuser = 1'b0;
    endtask

    task automatic wait_drain(input int n);
        for (int t = 0; t < 3000 && got_q.size() < n; t++) @(posedge clk);
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v, input bit do_rst, input bit rnd, input string tag);
        int n;
        if (do_rst) do_reset();
        configure(v.w, v.h);
        stall_pct = v.stall;
        in_q.delete();
        data_ctr = 32'd1;
        for (int j = 0; j < v.junk; j++) in_q.push_back('{32'hDEAD_0000 + 32'(j), 1'b0});
        for (int s = 0; s < 4; s++) if (v.seg[s] > 0) add_seg(v.seg[s], rnd);
        n = v.w * v.h;
        model(n);
        send_beats(v.stall);
        wait_drain(exp_q.size());
        stall_pct = 0;
        chk({tag, "_beats"}, 64'(got_q.size()), (v.exp_beats < 0) ? 64'(exp_q.size()) : 64'(v.exp_beats));
        chk({tag, "_frames"}, 64'(fd_count), (v.exp_frames < 0) ? 64'(m_frames) : 64'(v.exp_frames));
        chk({tag, "_err_short"}, {48'd0, err_short_cnt}, (v.exp_short < 0) ? 64'(m_short) : 64'(v.exp_short));
        chk({tag, "_err_long"}, {48'd0, err_long_cnt}, (v.exp_long < 0) ? 64'(m_long) : 64'(v.exp_long));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            chk({tag, "_data"}, {32'd0, got_q[i].d}, {32'd0, exp_q[i].d});
            chk({tag, "_last"}, {63'd0, got_q[i].l}, {63'd0, exp_q[i].l});
        end
    endtask

    initial begin
        vec_t rv;
        vecs[0] = '{4, 2, 0, '{8, 0, 0, 0}, 0, 8, 1, 0, 0};
        vecs[1] = '{4, 2, 3, '{8, 0, 0, 0}, 0, 8, 1, 0, 0};
        vecs[2] = '{4, 2, 0, '{5, 8, 0, 0}, 0, 16, 2, 1, 0};
        vecs[3] = '{4, 2, 0, '{11, 0, 0, 0}, 0, 8, 1, 0, 1};
        vecs[4] = '{4, 2, 0, '{8, 8, 0, 0}, 50, 16, 2, 0, 0};
        vecs[5] = '{1, 1, 0, '{1, 1, 1, 0}, 0, 3, 3, 0, 0};
        vecs[6] = '{1, 1, 2, '{1, 3, 0, 0}, 30, 2, 2, 0, 1};
        vecs[7] = '{3, 3, 0, '{2, 9, 0, 0}, 30, 18, 2, 1, 0};

        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) run_vec(vecs[i], 1'b1, 1'b0, $sformatf("vec%0d", i));

        // Back-to-back throughput and single-cycle latency with ready held high.
        do_reset();
        configure(4, 2);
        stall_pct = 0;
        in_q.delete(); data_ctr = 32'd100;
        add_seg(8, 1'b0);
        send_beats(0);
        wait_drain(8);
        chk("tput_count", 64'(got_q.size()), 64'd8);
        if (got_q.size() == 8) begin
            chk("latency_first", 64'(got_cyc[0]), 64'(first_acc_cyc + 1));
            chk("tput_span", 64'(got_cyc[7] - got_cyc[0]), 64'd7);
        end

        // Zero-sized configurations are ignored.
        do_reset();
        configure(0, 3);
        configure(4, 0);
        configure(2, 2);

        // Reset in the middle of a frame with a stalled output.
        do_reset();
        configure(4, 2);
        stall_pct = 100;
        in_q.delete(); data_ctr = 32'd7;
        add_seg(2, 1'b0);
        send_beats(0);
        chk("pre_reset_valid", {63'd0, m_axis_tvalid}, 64'd1);
        rst = 1'b0;
        #1;
        chk("midrst_m_tvalid", {63'd0, m_axis_tvalid}, 64'd0);
        chk("midrst_m_tdata", {32'd0, m_axis_tdata}, 64'd0);
        chk("midrst_m_tlast", {63'd0, m_axis_tlast}, 64'd0);
        chk("midrst_s_tready", {63'd0, s_axis_tready}, 64'd0);
        stall_pct = 0;
        got_q.delete(); got_cyc.delete(); fd_count = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        chk("midrst_cfg_ready", {63'd0, cfg_ready}, 64'd1);
        s_axis_tvalid = 1'b1; s_axis_tuser = 1'b1; s_axis_tdata = 32'h5A5A_5A5A;
        repeat (5) @(posedge clk);
        #1;
        chk("unconfigured_out", 64'(got_q.size()), 64'd0);
        chk("unconfigured_tready", {63'd0, s_axis_tready}, 64'd0);
        s_axis_tvalid = 1'b0; s_axis_tuser = 1'b0;
        run_vec(vecs[0], 1'b0, 1'b0, "post_rst");

        // Randomized frames against the reference model.
        for (int it = 0; it < 15; it++) begin
            int nseg, n;
            rv.w = $urandom_range(1, 5);
            rv.h = $urandom_range(1, 4);
            n = rv.w * rv.h;
            rv.junk = $urandom_range(0, 3);
            rv.stall = $urandom_range(0, 60);
            nseg = $urandom_range(1, 4);
            for (int s = 0; s < 4; s++) begin
                if (s < nseg - 1) rv.seg[s] = $urandom_range(1, n + 3);
                else if (s == nseg - 1) rv.seg[s] = $urandom_range(n, n + 2);
                else rv.seg[s] = 0;
            end
            rv.exp_beats = -1; rv.exp_frames = -1; rv.exp_short = -1; rv.exp_long = -1;
            run_vec(rv, 1'b1, 1'b1, $sformatf("rnd%0d", it));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
